mem_port_arbiter: RTL and testbench

- Arbitrates one single-port unified memory between the instruction-fetch requester (I) and the load/store requester (D) in the rv32i core.
- Sits between the fetch/LSU stages and the memory macro.
- Issues at most one access per cycle with fixed priority to D and an anti-starvation override for I.
- Tracks in-flight accesses so each read response returns to the requester that issued it.

---
 rtl/mem_port_arbiter_if.sv | 62 ++++++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch (I), load/store (D) and memory-macro
//               signals of the unified memory port arbiter.
//               slave  modport : arbiter side (drives grants, responses and
//                                the memory strobe/address/data)
//               master modport : environment side (requesters + memory)
//               Ports carried:
//                 i_req, i_addr, i_gnt, i_rvalid, i_rdata
//                 d_req, d_we, d_be, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata
//                 mem_en, mem_we, mem_be, mem_addr, mem_wdata, mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_W-1:0]     i_rdata;

    // load/store requester
    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    // memory macro
    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port unified memory between the fetch
//               requester (I) and the load/store requester (D).
//               - one access per cycle, grant and memory drive combinational
//                 in the request cycle
//               - D has fixed priority; I is forced through after it has been
//                 denied STARVE_MAX consecutive requesting cycles
//               - a MEM_LATENCY-deep tag pipeline routes every response back
//                 to the requester that issued it, in issue order
// Ports       : clk, rst_n (async, active low)
//               bus   : mem_port_arbiter_if.slave (I, D and memory signals)
//               stat_i_grants / stat_d_grants / stat_conflicts (32-bit,
//               wrapping) exist only when MEM_ARB_STATS_EN is defined
// Options     : `define MEM_ARB_STATS_EN to add the grant/conflict counters
// Parameters  : ADDR_W, DATA_W, MEM_LATENCY (1..4), STARVE_MAX
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    mem_port_arbiter_if.slave    bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]          stat_i_grants,
    output logic [31:0]          stat_d_grants,
    output logic [31:0]          stat_conflicts
`endif
);

    localparam int c_BE_W  = DATA_W / 8;
    localparam int c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               w_starved;
    logic               w_i_gnt;
    logic               w_d_gnt;
    logic               w_mem_en;
    logic               w_d_store;

    assign w_starved = (r_starve_cnt == c_STARVE_MAX);

    // Grants are qualified by rst_n so that nothing reaches the memory or the
    // requesters while reset is held, even with requests asserted.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (rst_n) begin
            if (bus.d_req && !(bus.i_req && w_starved)) begin
                w_d_gnt = 1'b1;
            end else if (bus.i_req) begin
                w_i_gnt = 1'b1;
            end
        end
    end

    assign w_mem_en  = w_i_gnt | w_d_gnt;
    assign w_d_store = w_d_gnt & bus.d_we;

    // Counts consecutive cycles in which I is requesting but not granted.
    // Saturates so that I keeps its forced priority until it is served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (bus.i_req && !w_i_gnt) begin
            if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Memory drive (same cycle as the grant)
    // ------------------------------------------------------------------------
    assign bus.i_gnt     = w_i_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_d_store;
    assign bus.mem_be    = w_d_store ? bus.d_be
                         : (w_mem_en ? {c_BE_W{1'b1}} : {c_BE_W{1'b0}});
    assign bus.mem_addr  = w_d_gnt ? bus.d_addr
                         : (w_i_gnt ? bus.i_addr : {ADDR_W{1'b0}});
    assign bus.mem_wdata = w_d_store ? bus.d_wdata : {DATA_W{1'b0}};

    // ------------------------------------------------------------------------
    // Response tag pipeline
    // Bit 0 holds the tag of the access issued in the previous cycle; the tag
    // in bit MEM_LATENCY-1 lines up with the cycle in which mem_rdata for
    // that access is valid.
    // ------------------------------------------------------------------------
    logic [MEM_LATENCY-1:0] r_tag_vld;
    logic [MEM_LATENCY-1:0] r_tag_own_d;
    logic [MEM_LATENCY-1:0] r_tag_wr;

    generate
        if (MEM_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag_vld   <= '0;
                    r_tag_own_d <= '0;
                    r_tag_wr    <= '0;
                end else begin
                    r_tag_vld   <= w_mem_en;
                    r_tag_own_d <= w_d_gnt;
                    r_tag_wr    <= w_d_store;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag_vld   <= '0;
                    r_tag_own_d <= '0;
                    r_tag_wr    <= '0;
                end else begin
                    r_tag_vld   <= {r_tag_vld[MEM_LATENCY-2:0],   w_mem_en};
                    r_tag_own_d <= {r_tag_own_d[MEM_LATENCY-2:0], w_d_gnt};
                    r_tag_wr    <= {r_tag_wr[MEM_LATENCY-2:0],    w_d_store};
                end
            end
        end
    endgenerate

    logic w_out_vld;
    logic w_out_own_d;
    logic w_out_wr;

    assign w_out_vld   = r_tag_vld[MEM_LATENCY-1];
    assign w_out_own_d = r_tag_own_d[MEM_LATENCY-1];
    assign w_out_wr    = r_tag_wr[MEM_LATENCY-1];

    // Data is steered only to the owner; the other side always sees zero.
    // A store acknowledge carries zero data rather than whatever the macro
    // happens to present.
    assign bus.i_rvalid = w_out_vld & ~w_out_own_d;
    assign bus.d_rvalid = w_out_vld &  w_out_own_d;
    assign bus.i_rdata  = (w_out_vld && !w_out_own_d) ? bus.mem_rdata
                                                      : {DATA_W{1'b0}};
    assign bus.d_rdata  = (w_out_vld && w_out_own_d && !w_out_wr) ? bus.mem_rdata
                                                                  : {DATA_W{1'b0}};

`ifdef MEM_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------------
    logic [31:0] r_stat_i_grants;
    logic [31:0] r_stat_d_grants;
    logic [31:0] r_stat_conflicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_i_grants  <= 32'd0;
            r_stat_d_grants  <= 32'd0;
            r_stat_conflicts <= 32'd0;
        end else begin
            if (w_i_gnt) begin
                r_stat_i_grants <= r_stat_i_grants + 32'd1;
            end
            if (w_d_gnt) begin
                r_stat_d_grants <= r_stat_d_grants + 32'd1;
            end
            if (bus.i_req && bus.d_req) begin
                r_stat_conflicts <= r_stat_conflicts + 32'd1;
            end
        end
    end

    assign stat_i_grants  = r_stat_i_grants;
    assign stat_d_grants  = r_stat_d_grants;
    assign stat_conflicts = r_stat_conflicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter.
//               dut  : MEM_LATENCY=1, STARVE_MAX=4, backed by a small word
//                      memory model; a reference arbiter predicts grants and
//                      queues expected responses, which are popped when due.
//               dut3 : MEM_LATENCY=3, used for mid-access reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rst3_n = 1'b0;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] st_i, st_d, st_c;
    logic [31:0] st3_i, st3_d, st3_c;
`endif

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .STARVE_MAX(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_i_grants  (st_i),
        .stat_d_grants  (st_d),
        .stat_conflicts (st_c)
`endif
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .STARVE_MAX(4)) dut3 (
        .clk            (clk),
        .rst_n          (rst3_n),
        .bus            (bus3)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_i_grants  (st3_i),
        .stat_d_grants  (st3_d),
        .stat_conflicts (st3_c)
`endif
    );

    // ------------------------------------------------------------------------
    // Memory model for dut: 256 words, registered read (latency 1)
    // ------------------------------------------------------------------------
    logic [31:0] mem [0:255];
    logic [31:0] rd_q = 32'h0;

    function automatic logic [31:0] pat(input int i);
        return (i == 15) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                rd_q <= mem[bus.mem_addr[9:2]];
            end
        end
    end

    assign bus.mem_rdata  = rd_q;
    assign bus3.mem_rdata = 32'hDEADBEEF;

    // ------------------------------------------------------------------------
    // Reference arbiter + response scoreboard for dut
    // ------------------------------------------------------------------------
    typedef struct {
        bit          own_d;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    bit   mon_ed, mon_ei;
    int   m_starve = 0;
    int   m_conf   = 0;
    int   m_gnts   = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_ed = bus.d_req && !(bus.i_req && m_starve == 4);
            mon_ei = bus.i_req && !mon_ed;
            n_cmp++;
            if (bus.i_gnt !== mon_ei || bus.d_gnt !== mon_ed) begin
                n_bad++;
                $display("FAIL grant cyc=%0d: got i=%b d=%b, expected i=%b d=%b",
                         cyc, bus.i_gnt, bus.d_gnt, mon_ei, mon_ed);
            end
            if (bus.i_req && !mon_ei) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
            else                      m_starve = 0;
            if (bus.i_req && bus.d_req) m_conf++;
            if (mon_ei || mon_ed)       m_gnts++;

            // response due this cycle?
            n_cmp++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.own_d) begin
                    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== mon_e.data ||
                        bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h0) begin
                        n_bad++;
                        $display("FAIL d_resp cyc=%0d: got dv=%b dd=%h iv=%b id=%h, expected dv=1 dd=%h iv=0 id=0",
                                 cyc, bus.d_rvalid, bus.d_rdata, bus.i_rvalid, bus.i_rdata, mon_e.data);
                    end
                end else begin
                    if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== mon_e.data ||
                        bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin
                        n_bad++;
                        $display("FAIL i_resp cyc=%0d: got iv=%b id=%h dv=%b dd=%h, expected iv=1 id=%h dv=0 dd=0",
                                 cyc, bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata, mon_e.data);
                    end
                end
            end else begin
                if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 ||
                    bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
                    n_bad++;
                    $display("FAIL idle_resp cyc=%0d: got iv=%b dv=%b id=%h dd=%h, expected all 0",
                             cyc, bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata);
                end
            end

            if (mon_ed) sb.push_back('{own_d: 1'b1,
                                       data: bus.d_we ? 32'h0 : mem[bus.d_addr[9:2]],
                                       due: cyc + 1});
            if (mon_ei) sb.push_back('{own_d: 1'b0,
                                       data: mem[bus.i_addr[9:2]],
                                       due: cyc + 1});
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [137:0] outs;

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h44;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
        bus.d_addr = 32'h80; bus.d_wdata = 32'h5555AAAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            outs = {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we,
                    bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata};
            n_cmp++;
            if (outs !== 138'h0) begin
                n_bad++;
                $display("FAIL reset_outputs k=%0d: got %h, expected 0", k, outs);
            end
        end
        tick();
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_fetch_only();
        bus.i_req = 1'b1; bus.i_addr = 32'h3C;
        @(negedge clk);
        n_cmp++;
        if (bus.i_gnt !== 1'b1 || bus.mem_addr !== 32'h3C || bus.mem_en !== 1'b1 ||
            bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin
            n_bad++;
            $display("FAIL fetch_issue: got gnt=%b addr=%h en=%b we=%b be=%h, expected 1 0000003c 1 0 f",
                     bus.i_gnt, bus.mem_addr, bus.mem_en, bus.mem_we, bus.mem_be);
        end
        tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF || bus.d_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_resp: got iv=%b id=%h dv=%b, expected 1 deadbeef 0",
                     bus.i_rvalid, bus.i_rdata, bus.d_rvalid);
        end
        tick();
    endtask

    task automatic test_conflict();
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        @(negedge clk);
        n_cmp++;
        if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0 || bus.mem_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL conflict_first: got d=%b i=%b addr=%h, expected d=1 i=0 addr=00000100",
                     bus.d_gnt, bus.i_gnt, bus.mem_addr);
        end
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.i_gnt !== 1'b1 || bus.mem_addr !== 32'h40 || bus.d_rdata !== 32'hC0DE0040) begin
            n_bad++;
            $display("FAIL conflict_second: got i=%b addr=%h dd=%h, expected i=1 addr=00000040 dd=c0de0040",
                     bus.i_gnt, bus.mem_addr, bus.d_rdata);
        end
        tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hC0DE0010 || bus.d_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL conflict_i_resp: got iv=%b id=%h dd=%h, expected 1 c0de0010 0",
                     bus.i_rvalid, bus.i_rdata, bus.d_rdata);
        end
        tick();
    endtask

    task automatic test_store();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h200; bus.d_wdata = 32'h1234;
        @(negedge clk);
        n_cmp++;
        if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0011 ||
            bus.mem_wdata !== 32'h1234 || bus.mem_addr !== 32'h200) begin
            n_bad++;
            $display("FAIL store_issue: got gnt=%b we=%b be=%b wd=%h addr=%h, expected 1 1 0011 00001234 00000200",
                     bus.d_gnt, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
        end
        tick();
        // load the same word straight behind the store
        bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_wdata = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin
            n_bad++;
            $display("FAIL store_ack: got dv=%b dd=%h we=%b be=%h, expected 1 0 0 f",
                     bus.d_rvalid, bus.d_rdata, bus.mem_we, bus.mem_be);
        end
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hC0DE1234) begin
            n_bad++;
            $display("FAIL store_readback: got dv=%b dd=%h, expected 1 c0de1234", bus.d_rvalid, bus.d_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int  nd = 0;
        bit  exp_i;
        bus.i_req = 1'b1; bus.i_addr = 32'h44;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
        bus.d_addr = 32'h300; bus.d_wdata = 32'h0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            exp_i = (k == 4);
            n_cmp++;
            if (bus.i_gnt !== exp_i || bus.d_gnt !== !exp_i) begin
                n_bad++;
                $display("FAIL starve k=%0d: got i=%b d=%b, expected i=%b d=%b",
                         k, bus.i_gnt, bus.d_gnt, exp_i, !exp_i);
            end
            tick();
            if (exp_i) bus.i_req = 1'b0;
            if (!exp_i) begin
                nd++;
                bus.d_addr  = 32'h300 + 32'(4 * nd);
                bus.d_wdata = 32'(nd);
            end
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_reset_midflight();
        bus3.i_req = 1'b0; bus3.i_addr = 32'h0;
        bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_be = 4'h0;
        bus3.d_addr = 32'h0; bus3.d_wdata = 32'h0;
        tick();
        rst3_n = 1'b1;
        bus3.i_req = 1'b1; bus3.i_addr = 32'h3C;
        @(negedge clk);
        n_cmp++;
        if (bus3.i_gnt !== 1'b1 || bus3.mem_addr !== 32'h3C) begin
            n_bad++;
            $display("FAIL lat3_first_gnt: got gnt=%b addr=%h, expected 1 0000003c", bus3.i_gnt, bus3.mem_addr);
        end
        tick();
        rst3_n = 1'b0;
        bus3.i_addr = 32'h40;
        @(negedge clk);
        outs = {bus3.i_gnt, bus3.d_gnt, bus3.i_rvalid, bus3.d_rvalid, bus3.mem_en, bus3.mem_we,
                bus3.mem_be, bus3.mem_addr, bus3.mem_wdata, bus3.i_rdata, bus3.d_rdata};
        n_cmp++;
        if (outs !== 138'h0) begin
            n_bad++;
            $display("FAIL lat3_reset_outputs: got %h, expected 0", outs);
        end
        tick();
        rst3_n = 1'b1;
        bus3.i_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus3.i_rvalid !== 1'b0 || bus3.d_rvalid !== 1'b0) begin
                n_bad++;
                $display("FAIL lat3_discard k=%0d: got iv=%b dv=%b, expected 0 0", k, bus3.i_rvalid, bus3.d_rvalid);
            end
            tick();
        end
        // fresh fetch after reset: data three cycles after the grant
        bus3.i_req = 1'b1; bus3.i_addr = 32'h8;
        @(negedge clk);
        n_cmp++;
        if (bus3.i_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL lat3_gnt: got %b, expected 1", bus3.i_gnt);
        end
        tick();
        bus3.i_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus3.i_rvalid !== (k == 3) || bus3.i_rdata !== ((k == 3) ? 32'hDEADBEEF : 32'h0)) begin
                n_bad++;
                $display("FAIL lat3_resp k=%0d: got iv=%b id=%h, expected iv=%b",
                         k, bus3.i_rvalid, bus3.i_rdata, (k == 3));
            end
            tick();
        end
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        int c0, g0;
        c0 = m_conf;
        g0 = m_gnts;
        bus.i_req = 1'b1; bus.i_addr = 32'h8;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'hC;
        for (int k = 0; k < 6; k++) tick();
        bus.d_req = 1'b0;
        for (int k = 0; k < 2; k++) tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (st_c !== 32'(c0 + 6)) begin
            n_bad++;
            $display("FAIL stat_conflicts: got %0d, expected %0d", st_c, c0 + 6);
        end
        n_cmp++;
        if (st_i + st_d !== 32'(g0 + 8)) begin
            n_bad++;
            $display("FAIL stat_grants: got %0d, expected %0d", st_i + st_d, g0 + 8);
        end
        tick();
        tick();
    endtask
`endif

    // ------------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------------
    initial begin
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus3.i_req = 1'b0; bus3.i_addr = 32'h0;
        bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_be = 4'h0;
        bus3.d_addr = 32'h0; bus3.d_wdata = 32'h0;
        #1;
        test_reset();
        test_fetch_only();
        test_conflict();
        test_store();
        test_back_to_back();
        test_reset_midflight();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
